// File: rtl/instr_fetch_unit.sv
// Purpose : MIPS fetch stage. Holds the PC, fetches one word at a time, hands words to decode, redirects on jump/branch.
// Latency : imem_req is issued in the IDLE cycle or in the decode-transfer cycle. A word is offered the cycle after imem_valid.
// Backpr. : a word is held stable while instr_valid & !dec_ready. No new request is issued until that word transfers.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   imem_req/imem_addr               one-cycle fetch request with a word-aligned address
//   imem_valid/imem_data             one-cycle response, at least one cycle after the request
//   instr/instr_pc/instr_valid       word to decode and its address; dec_ready accepts it
//   jump/branch/alu_zero             redirect controls from the control unit and the ALU
//   ex_pc/br_offset/jmp_index        operands for the redirect target
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            dec_ready,
  input  logic            jump,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [15:0]     br_offset,
  input  logic [25:0]     jmp_index
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // A jump keeps only the region bits of ex_pc+4 above bit 27.
  localparam logic [PC_W-1:0] REGION_MASK = ~PC_W'(28'hFFF_FFFF);

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] last_addr;
  logic            drop;

  logic            redir;
  logic            xfer;
  logic            issue;
  logic            drop_next;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] target;

  assign redir   = jump | (branch & alu_zero);
  assign xfer    = instr_valid & dec_ready;
  assign seq_pc  = ex_pc + PC_W'(4);
  assign jmp_tgt = (seq_pc & REGION_MASK) | PC_W'({jmp_index, 2'b00});
  assign br_tgt  = seq_pc + {{(PC_W-18){br_offset[15]}}, br_offset, 2'b00};
  assign target  = jump ? jmp_tgt : br_tgt;

  // A request is abandoned while still in flight (reset or redirect out of WAIT).
  // Its late response must be swallowed. A response arriving in the same cycle is
  // simply not captured, so no drop is needed for it.
  assign drop_next = (drop | (state == S_WAIT)) & ~imem_valid;

  // Requests are issued combinationally so a transfer and the next fetch share a cycle.
  // While a dropped response is still pending, IDLE waits for it. This keeps at most
  // one word in flight.
  assign issue = ~reset & ~redir &
                 (((state == S_IDLE) & ~drop) | ((state == S_HOLD) & xfer));

  assign imem_req  = issue;
  assign imem_addr = issue ? pc : last_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      last_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      drop        <= drop_next;
    end else begin
      if (issue) begin
        last_addr <= pc;
      end
      if (redir) begin
        // Redirect flushes any held word; a coincident transfer does not count.
        pc          <= target;
        instr_valid <= 1'b0;
        drop        <= drop_next;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (drop) begin
              if (imem_valid) begin
                drop <= 1'b0;
              end
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_IDLE;
              end else begin
                instr       <= imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + PC_W'(4);
                state       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (xfer) begin
              instr_valid <= 1'b0;
              state       <= S_WAIT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        jump;
  logic        branch;
  logic        alu_zero;
  logic [31:0] ex_pc;
  logic [15:0] br_offset;
  logic [25:0] jmp_index;

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dec_ready(dec_ready), .jump(jump), .branch(branch), .alu_zero(alu_zero),
    .ex_pc(ex_pc), .br_offset(br_offset), .jmp_index(jmp_index)
  );

  // Stimulus for the next cycle, applied at the falling edge by step().
  logic        s_reset, s_ready, s_jump, s_branch, s_zero;
  logic [31:0] s_expc;
  logic [15:0] s_off;
  logic [25:0] s_idx;

  // Memory model: returns the address as data, mem_lat cycles after the request.
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t mq[$];
  int    mem_lat;
  int    cyc;

  // Observations of the current cycle.
  logic        o_req, o_ivld, o_xfer, o_redir, o_busy;
  logic [31:0] o_addr, o_instr, o_ipc;

  int n_cmp;
  int n_fail;

  task automatic clear_stim();
    s_jump = 0; s_branch = 0; s_zero = 0; s_expc = 0; s_off = 0; s_idx = 0; s_reset = 0;
  endtask

  task automatic step();
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_data  = mq[0].addr;
      void'(mq.pop_front());
    end
    reset = s_reset; dec_ready = s_ready; jump = s_jump; branch = s_branch;
    alu_zero = s_zero; ex_pc = s_expc; br_offset = s_off; jmp_index = s_idx;
    #1;
    o_busy  = (mq.size() != 0);
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_ivld  = instr_valid;
    o_instr = instr;
    o_ipc   = instr_pc;
    o_xfer  = instr_valid & s_ready;
    o_redir = s_jump | (s_branch & s_zero);
    if (imem_req) mq.push_back('{cyc + mem_lat, imem_addr});
    cyc++;
  endtask

  task automatic wait_ivld(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_ivld) begin ok = 1; break; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_req) begin ok = 1; break; end
    end
  endtask

  task automatic wait_xfer(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_xfer) begin ok = 1; break; end
    end
  endtask

  // Reference redirect target from the architectural rules.
  function automatic logic [31:0] ref_target(input logic j, input logic [31:0] ex,
                                             input logic [15:0] off, input logic [25:0] idx);
    logic [31:0] nxt;
    int          soff;
    nxt  = ex + 32'd4;
    soff = int'($signed(off));
    if (j) return (nxt & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
    return nxt + 32'(soff * 4);
  endfunction

  task automatic test_reset();
    clear_stim(); mem_lat = 1; s_ready = 1; s_reset = 1;
    step(); step();
    n_cmp++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_req); end
    n_cmp++; if (o_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_addr); end
    n_cmp++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
    n_cmp++; if (o_ipc !== 32'h0) begin n_fail++; $display("FAIL reset_ipc: got %h want 0", o_ipc); end
    n_cmp++; if (o_ivld !== 1'b0) begin n_fail++; $display("FAIL reset_ivld: got %b want 0", o_ivld); end
    s_reset = 0;
  endtask

  task automatic test_sequential();
    int          rc[$];
    logic [31:0] ra[$];
    logic [31:0] xp[$];
    s_ready = 1;
    for (int i = 0; i < 20 && xp.size() < 3; i++) begin
      step();
      if (o_req) begin rc.push_back(cyc); ra.push_back(o_addr); end
      if (o_xfer) begin
        xp.push_back(o_ipc);
        n_cmp++; if (o_instr !== o_ipc) begin n_fail++; $display("FAIL seq_data: got %h want %h", o_instr, o_ipc); end
      end
    end
    n_cmp++;
    if (xp.size() < 3 || ra.size() < 3) begin
      n_fail++; $display("FAIL seq_timeout: got %0d transfers want 3", xp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (ra[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_req_addr%0d: got %h want %h", i, ra[i], 4 * i); end
        n_cmp++; if (xp[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_instr_pc%0d: got %h want %h", i, xp[i], 4 * i); end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++; if (rc[i] - rc[i-1] != 2) begin n_fail++; $display("FAIL seq_req_gap%0d: got %0d want 2", i, rc[i] - rc[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] h_instr, h_ipc;
    s_ready = 0;
    wait_ivld(20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no instr_valid want 1"); end
    h_instr = o_instr; h_ipc = o_ipc;
    n_cmp++; if (h_ipc !== 32'hC) begin n_fail++; $display("FAIL stall_ipc: got %h want 0000000c", h_ipc); end
    n_cmp++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL stall_req0: got %b want 0", o_req); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (o_ivld !== 1'b1) begin n_fail++; $display("FAIL stall_ivld: got %b want 1", o_ivld); end
      n_cmp++; if (o_instr !== h_instr || o_ipc !== h_ipc) begin
        n_fail++; $display("FAIL stall_stable: got %h/%h want %h/%h", o_instr, o_ipc, h_instr, h_ipc); end
      n_cmp++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", o_req); end
    end
    s_ready = 1;
    step();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== h_ipc + 32'd4) begin
      n_fail++; $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=%h", o_req, o_addr, h_ipc + 32'd4); end
  endtask

  task automatic test_redirect();
    bit ok;
    s_ready = 0;
    wait_ivld(20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL jmp_timeout: got no instr_valid want 1"); end
    s_jump = 1; s_expc = 32'h100; s_idx = 26'h10;
    step(); clear_stim(); step();
    n_cmp++; if (o_ivld !== 1'b0) begin n_fail++; $display("FAIL jmp_flush: got %b want 0", o_ivld); end
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin
      n_fail++; $display("FAIL jmp_target: got req=%b addr=%h want req=1 addr=00000040", o_req, o_addr); end
    wait_ivld(20, ok);
    n_cmp++; if (!ok || o_ipc !== 32'h40 || o_instr !== 32'h40) begin
      n_fail++; $display("FAIL jmp_fetch: got %h/%h want 00000040", o_ipc, o_instr); end
    s_branch = 1; s_zero = 1; s_expc = 32'h20; s_off = 16'hFFFE;
    step(); clear_stim(); step();
    n_cmp++; if (o_ivld !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h1C) begin
      n_fail++; $display("FAIL br_target: got ivld=%b req=%b addr=%h want 0/1/0000001c", o_ivld, o_req, o_addr); end
    wait_ivld(20, ok);
    n_cmp++; if (!ok || o_ipc !== 32'h1C) begin n_fail++; $display("FAIL br_fetch: got %h want 0000001c", o_ipc); end
    s_branch = 1; s_zero = 0; s_expc = 32'h80; s_off = 16'h5;
    step(); clear_stim(); step();
    n_cmp++; if (o_ivld !== 1'b1 || o_ipc !== 32'h1C || o_req !== 1'b0) begin
      n_fail++; $display("FAIL br_untaken: got ivld=%b ipc=%h req=%b want 1/0000001c/0", o_ivld, o_ipc, o_req); end
    s_jump = 1; s_branch = 1; s_zero = 1; s_expc = 32'h1000; s_idx = 26'h123; s_off = 16'h4;
    step(); clear_stim(); step();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h48C) begin
      n_fail++; $display("FAIL jmp_priority: got req=%b addr=%h want req=1 addr=0000048c", o_req, o_addr); end
  endtask

  task automatic test_redirect_in_wait();
    bit ok;
    mem_lat = 3; s_ready = 1;
    wait_req(20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wait_redir_timeout: got no req want 1"); end
    s_jump = 1; s_expc = 32'h200; s_idx = 26'hC0;
    step(); clear_stim();
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++; if (o_ivld !== 1'b0) begin n_fail++; $display("FAIL wait_redir_ivld: got %b want 0", o_ivld); end
      if (o_req) begin ok = 1; break; end
    end
    n_cmp++; if (!ok || o_addr !== 32'h300 || o_busy) begin
      n_fail++; $display("FAIL wait_redir_req: got ok=%b addr=%h busy=%b want 1/00000300/0", ok, o_addr, o_busy); end
    wait_xfer(20, ok);
    n_cmp++; if (!ok || o_ipc !== 32'h300 || o_instr !== 32'h300) begin
      n_fail++; $display("FAIL wait_redir_fetch: got %h/%h want 00000300", o_ipc, o_instr); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    s_reset = 1; step(); s_reset = 0; step();
    n_cmp++; if (o_req !== 1'b0 || o_addr !== 32'h0 || o_ivld !== 1'b0 || o_instr !== 32'h0 || o_ipc !== 32'h0) begin
      n_fail++; $display("FAIL rstwait_outputs: got req=%b addr=%h ivld=%b instr=%h ipc=%h want all 0",
                         o_req, o_addr, o_ivld, o_instr, o_ipc); end
    wait_req(20, ok);
    n_cmp++; if (!ok || o_addr !== 32'h0 || o_busy) begin
      n_fail++; $display("FAIL rstwait_req: got ok=%b addr=%h busy=%b want 1/00000000/0", ok, o_addr, o_busy); end
    wait_xfer(20, ok);
    n_cmp++; if (!ok || o_ipc !== 32'h0 || o_instr !== 32'h0) begin
      n_fail++; $display("FAIL rstwait_fetch: got %h/%h want 00000000", o_ipc, o_instr); end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat = 1; s_ready = 1;
    s_jump = 1; s_expc = 32'hF000_0000; s_idx = 26'h3FF_FFFF;
    step(); clear_stim();
    wait_xfer(20, ok);
    n_cmp++; if (!ok || o_ipc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ipc: got %h want fffffffc", o_ipc); end
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=00000000", o_req, o_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_instr, p_ipc;
    logic        p_hold;
    for (int seg = 0; seg < 3; seg++) begin
      mem_lat = int'($urandom_range(1, 4));
      clear_stim(); s_reset = 1; s_ready = 1; step(); s_reset = 0;
      exp_pc = 32'h0; p_hold = 0; p_instr = 0; p_ipc = 0;
      for (int i = 0; i < 250; i++) begin
        s_ready  = ($urandom_range(0, 9) < 7);
        s_jump   = ($urandom_range(0, 99) < 4);
        s_branch = ($urandom_range(0, 99) < 8);
        s_zero   = $urandom_range(0, 1) == 1;
        s_expc   = {$urandom(), 2'b00} >> 2 << 2;
        s_off    = 16'($urandom());
        s_idx    = 26'($urandom());
        step();
        if (p_hold) begin
          n_cmp++; if (o_ivld !== 1'b1 || o_instr !== p_instr || o_ipc !== p_ipc) begin
            n_fail++; $display("FAIL rnd_hold: got %b/%h/%h want 1/%h/%h", o_ivld, o_instr, o_ipc, p_instr, p_ipc); end
        end
        if (o_redir) begin
          exp_pc = ref_target(s_jump, s_expc, s_off, s_idx);
        end else if (o_xfer) begin
          n_cmp++; if (o_ipc !== exp_pc || o_instr !== exp_pc) begin
            n_fail++; $display("FAIL rnd_xfer: got %h/%h want %h", o_ipc, o_instr, exp_pc); end
          exp_pc = exp_pc + 32'd4;
        end
        if (o_req) begin
          n_cmp++; if (o_busy || o_addr !== exp_pc) begin
            n_fail++; $display("FAIL rnd_req: got addr=%h busy=%b want addr=%h busy=0", o_addr, o_busy, exp_pc); end
        end
        p_hold  = o_ivld & ~o_xfer & ~o_redir;
        p_instr = o_instr;
        p_ipc   = o_ipc;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; mem_lat = 1;
    reset = 1; imem_valid = 0; imem_data = 0; dec_ready = 0; jump = 0; branch = 0;
    alu_zero = 0; ex_pc = 0; br_offset = 0; jmp_index = 0;
    clear_stim(); s_ready = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_in_wait();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
